// File: rtl/conv_mem_arbiter.sv
// Single-port memory arbiter for the convolution datapath: burst reads for
// window/filter fetch and single-byte result writebacks, round-robin on ties.
module conv_mem_arbiter #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int WDATA_W = 8,
   parameter int LEN_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_req,
   input  logic [ADDR_W-1:0]  rd_base,
   input  logic [LEN_W-1:0]   rd_len,
   output logic               rd_gnt,
   output logic [DATA_W-1:0]  rd_data,
   output logic               rd_valid,
   output logic               rd_done,
   input  logic               wr_req,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [WDATA_W-1:0] wr_data,
   output logic               wr_gnt,
   output logic               mem_w_r_en,
   output logic [ADDR_W-1:0]  mem_adr,
   output logic [WDATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic               busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic                prio_wr_q, prio_wr_d;
   logic                grant_wr, grant_rd;

   // Arbitration is only live in IDLE; gating with rst keeps every output low
   // while reset is asserted even though grants are combinational.
   assign grant_wr = rst && (state_q == ST_IDLE) && wr_req && (!rd_req || prio_wr_q);
   assign grant_rd = rst && (state_q == ST_IDLE) && rd_req && !grant_wr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         prio_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         prio_wr_q <= prio_wr_d;
      end
   end

   // rem counts addresses still to issue after the grant cycle. rd_len-1 in
   // LEN_W bits gives N-1 directly, including rd_len=0 meaning 2**LEN_W words.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      prio_wr_d = prio_wr_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_wr) begin
               prio_wr_d = 1'b0;
            end else if (grant_rd) begin
               prio_wr_d = 1'b1;
               addr_d    = rd_base + ADDR_W'(1);
               rem_d     = rd_len - LEN_W'(1);
               state_d   = (rd_len == LEN_W'(1)) ? ST_DRAIN : ST_READ;
            end
         end
         ST_READ: begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
         end
         ST_DRAIN: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_gnt     = 1'b0;
      rd_valid   = 1'b0;
      rd_done    = 1'b0;
      wr_gnt     = 1'b0;
      mem_w_r_en = 1'b0;
      mem_adr    = '0;
      mem_wdata  = '0;
      busy       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_wr) begin
               wr_gnt     = 1'b1;
               mem_w_r_en = 1'b1;
               mem_adr    = wr_addr;
               mem_wdata  = wr_data;
            end else if (grant_rd) begin
               rd_gnt  = 1'b1;
               mem_adr = rd_base;
            end
         end
         ST_READ: begin
            mem_adr  = addr_q;
            rd_valid = 1'b1;
            busy     = 1'b1;
         end
         ST_DRAIN: begin
            rd_valid = 1'b1;
            rd_done  = 1'b1;
            busy     = 1'b1;
         end
         default: ;
      endcase
   end

   assign rd_data = rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Bench for conv_mem_arbiter: directed scenarios plus random traffic, checked
// each cycle against a queue-based model of issued addresses and pending words.
module tb_conv_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        rd_req;
   logic [9:0]  rd_base;
   logic [3:0]  rd_len;
   logic        rd_gnt;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_done;
   logic        wr_req;
   logic [9:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        wr_gnt;
   logic        mem_w_r_en;
   logic [9:0]  mem_adr;
   logic [7:0]  mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   conv_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_base(rd_base), .rd_len(rd_len), .rd_gnt(rd_gnt),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .mem_w_r_en(mem_w_r_en), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] fmem(input logic [9:0] a);
      return {16'hC0DE, 6'd0, a};
   endfunction

   // Registered memory: data for the address presented this cycle appears next cycle.
   always @(posedge clk) mem_rdata <= fmem(mem_adr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: addresses still to be issued, and addresses whose word
   // is due on a following cycle. Burst active <=> a word is pending.
   logic [9:0] addr_pend[$];
   logic [9:0] word_pend[$];
   bit         m_prio_wr;
   bit         g_rd, g_wr;

   task automatic model_cycle();
      logic        e_rgnt, e_wgnt, e_wen, e_valid, e_done, e_busy;
      logic [9:0]  e_adr, ia, va;
      logic [7:0]  e_wdata;
      logic [31:0] e_data;
      int          n;
      e_rgnt = 0; e_wgnt = 0; e_wen = 0; e_valid = 0; e_done = 0; e_busy = 0;
      e_adr = '0; e_wdata = '0; e_data = '0;
      g_rd = 0; g_wr = 0;
      if (!rst) begin
         addr_pend.delete();
         word_pend.delete();
         m_prio_wr = 0;
      end else if (word_pend.size() != 0) begin
         e_busy  = 1;
         e_valid = 1;
         va      = word_pend.pop_front();
         e_data  = fmem(va);
         if (addr_pend.size() != 0) begin
            ia    = addr_pend.pop_front();
            e_adr = ia;
            word_pend.push_back(ia);
         end else begin
            e_done = 1;
         end
      end else if (wr_req && (!rd_req || m_prio_wr)) begin
         g_wr = 1; e_wgnt = 1; e_wen = 1; e_adr = wr_addr; e_wdata = wr_data;
         m_prio_wr = 0;
      end else if (rd_req) begin
         g_rd = 1; e_rgnt = 1; e_adr = rd_base;
         n = (rd_len == 0) ? 16 : int'(rd_len);
         word_pend.push_back(rd_base);
         for (int k = 1; k < n; k++) addr_pend.push_back(rd_base + 10'(k));
         m_prio_wr = 1;
      end
      check("rd_gnt",     32'(rd_gnt),     32'(e_rgnt));
      check("wr_gnt",     32'(wr_gnt),     32'(e_wgnt));
      check("mem_w_r_en", 32'(mem_w_r_en), 32'(e_wen));
      check("mem_adr",    32'(mem_adr),    32'(e_adr));
      check("mem_wdata",  32'(mem_wdata),  32'(e_wdata));
      check("rd_valid",   32'(rd_valid),   32'(e_valid));
      check("rd_done",    32'(rd_done),    32'(e_done));
      check("busy",       32'(busy),       32'(e_busy));
      if (e_valid) check("rd_data", rd_data, e_data);
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input bit rd, input logic [9:0] base, input logic [3:0] len,
                          input bit wr, input logic [9:0] wa, input logic [7:0] wd);
      int budget;
      rd_req = rd; rd_base = base; rd_len = len;
      wr_req = wr; wr_addr = wa; wr_data = wd;
      budget = 200;
      while ((rd_req || wr_req || word_pend.size() != 0) && budget > 0) begin
         step();
         if (g_rd) rd_req = 0;
         if (g_wr) wr_req = 0;
         budget--;
      end
      if (budget == 0) check("run_req_timeout", 32'(budget), 32'(1));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_gnt"},  32'(rd_gnt),     32'(0));
      check({tag, "_wr_gnt"},  32'(wr_gnt),     32'(0));
      check({tag, "_w_r_en"},  32'(mem_w_r_en), 32'(0));
      check({tag, "_adr"},     32'(mem_adr),    32'(0));
      check({tag, "_wdata"},   32'(mem_wdata),  32'(0));
      check({tag, "_valid"},   32'(rd_valid),   32'(0));
      check({tag, "_done"},    32'(rd_done),    32'(0));
      check({tag, "_busy"},    32'(busy),       32'(0));
      check({tag, "_rd_data"}, rd_data,         32'(0));
   endtask

   initial begin
      rst = 0; rd_req = 0; rd_base = '0; rd_len = '0;
      wr_req = 0; wr_addr = '0; wr_data = '0; m_prio_wr = 0;
      // Requests asserted during reset must not be granted.
      #1 rd_req = 1; wr_req = 1;
      step();
      step();
      rd_req = 0; wr_req = 0;
      rst = 1;
      step();

      // Tie after reset: read first, write at the first IDLE cycle, then read again.
      run_req(1, 10'h010, 4'd4, 1, 10'h0AA, 8'h55);
      run_req(1, 10'h020, 4'd2, 1, 10'h0AB, 8'h56);
      run_req(0, '0, '0, 1, 10'h005, 8'hA7);
      run_req(1, 10'h3FE, 4'd4, 0, '0, '0);
      run_req(1, 10'h100, 4'd0, 0, '0, '0);
      run_req(1, 10'h200, 4'd1, 0, '0, '0);

      // Reset two cycles into a len=8 burst; the outputs drop at once.
      rd_req = 1; rd_base = 10'h180; rd_len = 4'd8;
      step(); rd_req = 0;
      step();
      rst = 0;
      #1 check_all_zero("rst_mid");
      step();
      step();
      rst = 1;
      rd_req = 1; rd_base = 10'h040; rd_len = 4'd3;
      @(negedge clk);
      check("post_rst_gnt", 32'(rd_gnt), 32'(1));
      model_cycle();
      @(posedge clk); #1;
      rd_req = 0;
      run_req(0, '0, '0, 0, '0, '0);

      // Random traffic with occasional request withdrawal before grant.
      for (int c = 0; c < 3000; c++) begin
         step();
         if (g_rd) rd_req = 0;
         if (g_wr) wr_req = 0;
         if (!rd_req && $urandom_range(0, 5) == 0) begin
            rd_req = 1; rd_base = 10'($urandom); rd_len = 4'($urandom);
         end else if (rd_req && $urandom_range(0, 39) == 0) begin
            rd_req = 0;
         end
         if (!wr_req && $urandom_range(0, 2) == 0) begin
            wr_req = 1; wr_addr = 10'($urandom); wr_data = 8'($urandom);
         end else if (wr_req && $urandom_range(0, 39) == 0) begin
            wr_req = 0;
         end
      end
      rd_req = 0; wr_req = 0;
      run_req(0, '0, '0, 0, '0, '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
